// File: rtl/mcs_wb_multi_bridge.sv
// MicroBlaze MCS I/O-bus to multi-slave Wishbone classic bridge.
// One Wishbone cycle per MCS strobe, with a timeout watchdog and sticky error status.
module mcs_wb_multi_bridge #(
   parameter logic [31:0] BRG_BASE   = 32'hc000_0000,
   parameter int          ADDR_WIDTH = 21,
   parameter int          DATA_WIDTH = 32,
   parameter int          N_SLV      = 4,
   parameter int          TIMEOUT    = 255
) (
   input  logic                  clk,
   input  logic                  reset,
   input  logic                  io_addr_strobe,
   input  logic                  io_read_strobe,
   input  logic                  io_write_strobe,
   input  logic [3:0]            io_byte_enable,
   input  logic [31:0]           io_address,
   input  logic [31:0]           io_write_data,
   output logic [31:0]           io_read_data,
   output logic                  io_ready,
   output logic                  wb_cyc,
   output logic [N_SLV-1:0]      wb_stb,
   output logic                  wb_we,
   output logic [3:0]            wb_sel,
   output logic [ADDR_WIDTH-1:0] wb_adr,
   output logic [31:0]           wb_dat_o,
   input  logic [N_SLV*32-1:0]   wb_dat_i,
   input  logic [N_SLV-1:0]      wb_ack,
   input  logic                  clr_err,
   output logic                  err_flag,
   output logic [7:0]            err_cnt
);

   localparam int SEL_W = (N_SLV > 1) ? $clog2(N_SLV) : 0;
   localparam int IDX_W = (SEL_W > 0) ? SEL_W : 1;
   localparam int CNT_W = 16;
   localparam logic [CNT_W:0] TMO_L = (CNT_W + 1)'(TIMEOUT);

   generate
      if (DATA_WIDTH != 32) begin : g_bad_data_width
         $error("mcs_wb_multi_bridge: DATA_WIDTH must be 32");
      end
      if (N_SLV < 1 || N_SLV > 16) begin : g_bad_n_slv
         $error("mcs_wb_multi_bridge: N_SLV must be 1..16");
      end
      if (TIMEOUT < 1 || TIMEOUT > 65535) begin : g_bad_timeout
         $error("mcs_wb_multi_bridge: TIMEOUT must be 1..65535");
      end
   endgenerate

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_RESP = 2'd2
   } state_t;

   state_t                  state_reg, state_next;
   logic [ADDR_WIDTH-1:0]   adr_reg, adr_next;
   logic [31:0]             dat_reg, dat_next;
   logic                    we_reg, we_next;
   logic [3:0]              sel_reg, sel_next;
   logic [IDX_W-1:0]        idx_reg, idx_next;
   logic                    err_reg, err_next;
   logic [CNT_W-1:0]        cnt_reg, cnt_next;
   logic [31:0]             rdata_reg, rdata_next;
   logic                    err_flag_reg, err_flag_next;
   logic [7:0]              err_cnt_reg, err_cnt_next;

   logic                    hit;
   logic [IDX_W-1:0]        idx_in;
   logic                    idx_bad;
   logic [N_SLV-1:0]        slv_onehot;
   logic                    ack_hit;
   logic [31:0]             rd_mux;
   logic [CNT_W:0]          cnt_inc;
   logic                    timeout_hit;
   logic                    unused_ok;

   assign hit = io_addr_strobe & (io_read_strobe | io_write_strobe) &
                (io_address[31:24] == BRG_BASE[31:24]);

   // Slave index is the top SEL_W bits of the word address.
   generate
      if (SEL_W > 0) begin : g_idx
         assign idx_in = io_address[ADDR_WIDTH+1 -: SEL_W];
      end else begin : g_idx_single
         assign idx_in = '0;
      end
      if (N_SLV == (1 << SEL_W)) begin : g_idx_full
         assign idx_bad = 1'b0;
      end else begin : g_idx_partial
         assign idx_bad = (idx_in >= IDX_W'(N_SLV));
      end
   endgenerate

   genvar gi;
   generate
      for (gi = 0; gi < N_SLV; gi++) begin : g_onehot
         assign slv_onehot[gi] = (idx_reg == IDX_W'(gi));
      end
   endgenerate

   assign ack_hit     = |(wb_ack & slv_onehot);
   assign cnt_inc     = {1'b0, cnt_reg} + {{CNT_W{1'b0}}, 1'b1};
   assign timeout_hit = (cnt_inc >= TMO_L);
   assign unused_ok   = ^io_address;

   always_comb begin
      rd_mux = '0;
      for (int i = 0; i < N_SLV; i++) begin
         if (slv_onehot[i]) begin
            rd_mux = rd_mux | wb_dat_i[i*32 +: 32];
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         state_reg    <= ST_IDLE;
         adr_reg      <= '0;
         dat_reg      <= '0;
         we_reg       <= 1'b0;
         sel_reg      <= '0;
         idx_reg      <= '0;
         err_reg      <= 1'b0;
         cnt_reg      <= '0;
         rdata_reg    <= '0;
         err_flag_reg <= 1'b0;
         err_cnt_reg  <= '0;
      end else begin
         state_reg    <= state_next;
         adr_reg      <= adr_next;
         dat_reg      <= dat_next;
         we_reg       <= we_next;
         sel_reg      <= sel_next;
         idx_reg      <= idx_next;
         err_reg      <= err_next;
         cnt_reg      <= cnt_next;
         rdata_reg    <= rdata_next;
         err_flag_reg <= err_flag_next;
         err_cnt_reg  <= err_cnt_next;
      end
   end

   always_comb begin
      state_next    = state_reg;
      adr_next      = adr_reg;
      dat_next      = dat_reg;
      we_next       = we_reg;
      sel_next      = sel_reg;
      idx_next      = idx_reg;
      err_next      = err_reg;
      cnt_next      = cnt_reg;
      rdata_next    = rdata_reg;
      err_flag_next = err_flag_reg;
      err_cnt_next  = err_cnt_reg;

      case (state_reg)
         ST_IDLE: begin
            cnt_next = '0;
            if (hit) begin
               adr_next = io_address[ADDR_WIDTH+1:2];
               dat_next = io_write_data;
               we_next  = io_write_strobe;
               sel_next = io_write_strobe ? io_byte_enable : 4'hf;
               idx_next = idx_in;
               if (idx_bad) begin
                  err_next   = 1'b1;
                  rdata_next = '0;
                  state_next = ST_RESP;
               end else begin
                  err_next   = 1'b0;
                  state_next = ST_BUS;
               end
            end
         end
         ST_BUS: begin
            cnt_next = cnt_inc[CNT_W-1:0];
            // A late ack in the final watchdog cycle still completes the access.
            if (ack_hit) begin
               rdata_next = we_reg ? 32'h0 : rd_mux;
               err_next   = 1'b0;
               state_next = ST_RESP;
            end else if (timeout_hit) begin
               rdata_next = '0;
               err_next   = 1'b1;
               state_next = ST_RESP;
            end
         end
         ST_RESP: begin
            cnt_next   = '0;
            state_next = ST_IDLE;
         end
         default: begin
            state_next = ST_IDLE;
         end
      endcase

      if (clr_err) begin
         err_flag_next = 1'b0;
         err_cnt_next  = '0;
      end else if (state_reg == ST_RESP && err_reg) begin
         err_flag_next = 1'b1;
         if (err_cnt_reg != 8'hff) begin
            err_cnt_next = err_cnt_reg + 8'd1;
         end
      end
   end

   assign wb_cyc       = (state_reg == ST_BUS);
   assign wb_stb       = wb_cyc ? slv_onehot : '0;
   assign wb_we        = we_reg;
   assign wb_sel       = sel_reg;
   assign wb_adr       = adr_reg;
   assign wb_dat_o     = dat_reg;
   assign io_ready     = (state_reg == ST_RESP);
   assign io_read_data = rdata_reg;
   assign err_flag     = err_flag_reg;
   assign err_cnt      = err_cnt_reg;

endmodule
